// File: rtl/mem_bus_if.sv
// Bus interface between mem_ctrl and data memory: one strobed access per request, variable wait states.
// Optional access timeout with a bus_err pulse is built when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_if #(
  parameter int unsigned ADDR_W      = 30,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wr_data,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              bus_err,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  if (TIMEOUT_CYC >= (2 ** CNT_W)) begin : g_cnt_w_check
    $error("CNT_W is too narrow to count up to TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  assign accept = req_valid & ~flush;
  // DONE deliberately releases the pipeline for one cycle before the next request can be taken.
  assign stall  = ((state == IDLE) && accept) || (state == BUSY);

`ifdef MEM_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst_) begin
      state       <= IDLE;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_data     <= '0;
      bus_err     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus_rw      <= req_rw;
            bus_addr    <= req_addr;
            bus_wr_data <= req_wr_data;
            bus_as_     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
            state       <= BUSY;
          end
        end
        BUSY: begin
`ifdef MEM_BUS_TIMEOUT_EN
          wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          // Reads may be abandoned on flush; stores always run to completion.
          if (flush && bus_rw) begin
            bus_as_ <= 1'b1;
            state   <= IDLE;
          end else if (!bus_rdy_) begin
            if (bus_rw) begin
              rd_data <= bus_rd_data;
            end
            bus_as_ <= 1'b1;
            state   <= DONE;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (timeout) begin
            bus_err <= 1'b1;
            bus_as_ <= 1'b1;
            if (bus_rw) begin
              rd_data <= '0;
            end
            state   <= DONE;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          bus_as_ <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Self-checking bench for mem_bus_if: directed and randomized accesses against a transaction-level model.
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        rst_;
  logic        req_valid;
  logic        req_rw;
  logic [29:0] req_addr;
  logic [31:0] req_wr_data;
  logic        flush;
  logic [31:0] rd_data;
  logic        stall;
  logic        bus_err;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd;

  mem_bus_if dut (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .flush(flush),
    .rd_data(rd_data), .stall(stall), .bus_err(bus_err), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access as mem_ctrl and slave see it: accept, (waits+1) strobed cycles, one release cycle.
  task automatic access(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits, input int flush_at,
                        input bit chain, input logic [29:0] next_addr);
    int stall_n;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wr_data = wd;
    flush = 1'b0; bus_rdy_ = 1'($urandom_range(0, 1));
    #1;
    total++;
    if (stall !== 1'b1 || bus_as_ !== 1'b1)
      $display("FAIL accept: stall=%b bus_as_=%b required stall=1 bus_as_=1", stall, bus_as_);
    if (stall !== 1'b1 || bus_as_ !== 1'b1) bad++;
    stall_n = 1;
    step();
    req_valid = 1'b0; req_addr = 30'($urandom); req_wr_data = $urandom;
    for (int b = 1; b <= waits + 1; b++) begin
      flush       = (b == flush_at);
      bus_rdy_    = (b == waits + 1) ? 1'b0 : 1'b1;
      bus_rd_data = (b == waits + 1) ? rdat : $urandom;
      #1;
      total++;
      if (bus_as_ !== 1'b0 || bus_rw !== rw || bus_addr !== addr || bus_wr_data !== wd || stall !== 1'b1) begin
        bad++;
        $display("FAIL busy_cycle%0d: as=%b rw=%b addr=%h wd=%h stall=%b required as=0 rw=%b addr=%h wd=%h stall=1",
                 b, bus_as_, bus_rw, bus_addr, bus_wr_data, stall, rw, addr, wd);
      end
      stall_n++;
      step();
      if (rw && b == flush_at) begin
        flush = 1'b0; bus_rdy_ = 1'b1;
        #1;
        total++;
        if (bus_as_ !== 1'b1 || stall !== 1'b0 || rd_data !== exp_rd) begin
          bad++;
          $display("FAIL flush_abort: as=%b stall=%b rd=%h required as=1 stall=0 rd=%h",
                   bus_as_, stall, rd_data, exp_rd);
        end
        step();
        return;
      end
    end
    flush = 1'b0;
    bus_rdy_ = 1'($urandom_range(0, 1));
    if (rw) exp_rd = rdat;
    if (chain) begin
      req_valid = 1'b1; req_rw = 1'b1; req_addr = next_addr;
    end
    #1;
    total++;
    if (bus_as_ !== 1'b1 || stall !== 1'b0 || rd_data !== exp_rd || bus_err !== 1'b0 || stall_n != waits + 2) begin
      bad++;
      $display("FAIL done: as=%b stall=%b rd=%h err=%b stall_cycles=%0d required as=1 stall=0 rd=%h err=0 stall_cycles=%0d",
               bus_as_, stall, rd_data, bus_err, stall_n, exp_rd, waits + 2);
    end
    step();
    bus_rdy_ = 1'b1;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wr_data = '0;
    flush = 1'b0; bus_rd_data = '0; bus_rdy_ = 1'b1;
    step(); step();
    total++;
    if (bus_as_ !== 1'b1 || bus_rw !== 1'b1 || bus_addr !== '0 || bus_wr_data !== '0 ||
        rd_data !== '0 || bus_err !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: as=%b rw=%b addr=%h wd=%h rd=%h err=%b stall=%b required 1 1 0 0 0 0 0",
               bus_as_, bus_rw, bus_addr, bus_wr_data, rd_data, bus_err, stall);
    end
    rst_ = 1'b0;
    exp_rd = '0;
    step();
  endtask

  task automatic test_directed();
    access(1'b1, 30'h10, 32'h0, 32'h0123_4567, 0, 0, 1'b0, '0);
    access(1'b0, 30'h4, 32'hDEAD_BEEF, 32'h5555_AAAA, 3, 0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    access(1'b1, 30'h0, 32'h0, 32'h1111_2222, 0, 0, 1'b1, 30'h1);
    access(1'b1, 30'h1, 32'h0, 32'h3333_4444, 0, 0, 1'b0, '0);
  endtask

  task automatic test_flush();
    access(1'b1, 30'h20, 32'h0, 32'hBAD0_BAD0, 3, 2, 1'b0, '0);
    access(1'b1, 30'h21, 32'h0, 32'hBAD1_BAD1, 2, 3, 1'b0, '0);
    access(1'b0, 30'h22, 32'hCAFE_F00D, 32'h0, 3, 2, 1'b0, '0);
    // Flush during the accept cycle must keep the request out.
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 30'h30; flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_stall: stall=%b required 0", stall);
    end
    step();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    total++;
    if (bus_as_ !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle_strobe: as=%b required 1", bus_as_);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic rw;
      int   waits;
      int   fa;
      rw    = 1'($urandom_range(0, 1));
      waits = int'($urandom_range(0, 4));
      fa    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, waits + 1)) : 0;
      access(rw, 30'($urandom), $urandom, $urandom, waits, fa, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_busy();
    access(1'b1, 30'h7, 32'h0, 32'h7777_0000, 0, 0, 1'b0, '0);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 30'h8; bus_rdy_ = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    exp_rd = '0;
    total++;
    if (bus_as_ !== 1'b1 || stall !== 1'b0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_mid_busy: as=%b stall=%b rd=%h required as=1 stall=0 rd=0", bus_as_, stall, rd_data);
    end
    step();
  endtask

  task automatic test_timeout();
    access(1'b1, 30'h9, 32'h0, 32'hA5A5_5A5A, 1, 0, 1'b0, '0);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 30'hA; bus_rdy_ = 1'b1;
    step();
    req_valid = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    for (int b = 1; b <= 16; b++) begin
      total++;
      if (bus_as_ !== 1'b0 || stall !== 1'b1 || bus_err !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait%0d: as=%b stall=%b err=%b required as=0 stall=1 err=0", b, bus_as_, stall, bus_err);
      end
      step();
    end
    exp_rd = '0;
    total++;
    if (bus_err !== 1'b1 || rd_data !== '0 || stall !== 1'b0 || bus_as_ !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err: err=%b rd=%h stall=%b as=%b required err=1 rd=0 stall=0 as=1", bus_err, rd_data, stall, bus_as_);
    end
    step();
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: err=%b required 0", bus_err);
    end
`else
    for (int b = 1; b <= 40; b++) begin
      total++;
      if (stall !== 1'b1 || bus_err !== 1'b0 || bus_as_ !== 1'b0) begin
        bad++;
        $display("FAIL no_timeout%0d: stall=%b err=%b as=%b required stall=1 err=0 as=0", b, stall, bus_err, bus_as_);
      end
      step();
    end
    rst_ = 1'b1;
    step();
    rst_ = 1'b0;
    exp_rd = '0;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid_busy();
    test_timeout();
    access(1'b1, 30'h3F, 32'h0, 32'h600D_600D, 2, 0, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
